// File: rtl/rr4_pkg.sv
// rr4_pkg: shared channel constants, FSM encoding and rotating priority search
// for the rr4 dispatch/merge family.
package rr4_pkg;
   localparam int CH_NUM = 4;
   localparam int CH_W   = 2;

   typedef enum logic {ST_IDLE = 1'b0, ST_LOCK = 1'b1} state_e;

   // Returns {found, index}; the search starts just after ptr and ends at ptr.
   function automatic logic [CH_W:0] rr_pick(input logic [CH_NUM-1:0] mask, input logic [CH_W-1:0] ptr);
      logic [CH_W-1:0] idx;
      rr_pick = '0;
      for (int k = CH_NUM; k >= 1; k--) begin
         idx = ptr + CH_W'(k);
         if (mask[idx]) rr_pick = {1'b1, idx};
      end
   endfunction
endpackage

// File: rtl/rr4_disp_obuf.sv
// rr4_disp_obuf: one-entry registered output stage, drains to the channel
// tagged on the stored beat and reloads in the same cycle when draining.
module rr4_disp_obuf
   import rr4_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic                clks,
   input  logic                reset,
   input  logic                load,
   input  logic [DATA_W-1:0]   in_data,
   input  logic                in_eop,
   input  logic [CH_W-1:0]     in_ch,
   input  logic [CH_NUM-1:0]   out_rdy,
   output logic                free,
   output logic [CH_NUM-1:0]   out_vld,
   output logic [DATA_W-1:0]   out_data,
   output logic                out_eop
);
   logic              obuf_vld_q, obuf_vld_d, obuf_eop_q, obuf_eop_d, drain;
   logic [DATA_W-1:0] obuf_data_q, obuf_data_d;
   logic [CH_W-1:0]   obuf_ch_q, obuf_ch_d;

   always_comb begin
      drain       = obuf_vld_q & out_rdy[obuf_ch_q];
      free        = !obuf_vld_q | drain;
      obuf_vld_d  = load | (obuf_vld_q & !drain);
      obuf_data_d = load ? in_data : obuf_data_q;
      obuf_eop_d  = load ? in_eop : obuf_eop_q;
      obuf_ch_d   = load ? in_ch : obuf_ch_q;
      out_vld     = {{(CH_NUM-1){1'b0}}, obuf_vld_q} << obuf_ch_q;
      out_data    = obuf_data_q;
      out_eop     = obuf_eop_q;
   end

   always_ff @(posedge clks) begin
      if (reset) begin
         obuf_vld_q  <= 1'b0;
         obuf_data_q <= '0;
         obuf_eop_q  <= 1'b0;
         obuf_ch_q   <= '0;
      end else begin
         obuf_vld_q  <= obuf_vld_d;
         obuf_data_q <= obuf_data_d;
         obuf_eop_q  <= obuf_eop_d;
         obuf_ch_q   <= obuf_ch_d;
      end
   end
endmodule

// File: rtl/rr4_dispatch.sv
// rr4_dispatch: packet round-robin distributor from one stream to 4 channels.
// Define RR4_DISPATCH_SKIP_BUSY_EN to skip channels not ready at packet start.
module rr4_dispatch
   import rr4_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic                clks,
   input  logic                reset,
   input  logic [CH_NUM-1:0]   ch_en,
   input  logic                in_vld,
   input  logic [DATA_W-1:0]   in_data,
   input  logic                in_eop,
   output logic                in_rdy,
   output logic [CH_NUM-1:0]   out_vld,
   output logic [DATA_W-1:0]   out_data,
   output logic                out_eop,
   input  logic [CH_NUM-1:0]   out_rdy,
   output logic [CH_W-1:0]     cur_ch
);
   state_e            state_q, state_d;
   logic [CH_W-1:0]   ptr_q, ptr_d, lock_ch_q, lock_ch_d, cand, obuf_ch;
   logic [CH_NUM-1:0] cand_mask;
   logic              cand_found, free, acc;

   always_comb begin
`ifdef RR4_DISPATCH_SKIP_BUSY_EN
      cand_mask = ch_en & out_rdy;
`else
      cand_mask = ch_en;
`endif
      {cand_found, cand} = rr_pick(cand_mask, ptr_q);
      // Gated by reset so nothing is accepted into a buffer that is being cleared.
      in_rdy    = !reset & free & ((state_q == ST_LOCK) | cand_found);
      acc       = in_vld & in_rdy;
      obuf_ch   = (state_q == ST_LOCK) ? lock_ch_q : cand;
      state_d   = acc ? (in_eop ? ST_IDLE : ST_LOCK) : state_q;
      lock_ch_d = (acc & (state_q == ST_IDLE)) ? cand : lock_ch_q;
      ptr_d     = (acc & (state_q == ST_IDLE)) ? cand : ptr_q;
      cur_ch    = (state_q == ST_LOCK) ? lock_ch_q : ptr_q;
   end

   always_ff @(posedge clks) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         ptr_q     <= CH_W'(3);
         lock_ch_q <= CH_W'(3);
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         lock_ch_q <= lock_ch_d;
      end
   end

   rr4_disp_obuf #(.DATA_W(DATA_W)) u_obuf (
      .clks     (clks),
      .reset    (reset),
      .load     (acc),
      .in_data  (in_data),
      .in_eop   (in_eop),
      .in_ch    (obuf_ch),
      .out_rdy  (out_rdy),
      .free     (free),
      .out_vld  (out_vld),
      .out_data (out_data),
      .out_eop  (out_eop)
   );
endmodule

// File: tb/tb_rr4_dispatch.sv
// tb_rr4_dispatch: directed and random stimulus against a transaction-level
// model of packet dealing and the one-beat output register.
module tb_rr4_dispatch;
`ifdef RR4_DISPATCH_SKIP_BUSY_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif
   logic        clks = 1'b0, reset = 1'b1;
   logic [3:0]  ch_en = 4'hF, out_rdy = 4'hF, out_vld;
   logic        in_vld = 1'b0, in_eop = 1'b0, in_rdy, out_eop;
   logic [63:0] in_data = '0, out_data, seq = '0;
   logic [1:0]  cur_ch;
   int          errs = 0, checks = 0;
   bit          mon_en = 1'b0;
   int          m_ptr = 3, m_lock = -1, e_ch = 0;
   bit          e_vld = 1'b0, e_eop = 1'b0;
   logic [63:0] e_data = '0;

   always #5 clks = ~clks;

   rr4_dispatch #(.DATA_W(64)) dut (
      .clks(clks), .reset(reset), .ch_en(ch_en), .in_vld(in_vld), .in_data(in_data),
      .in_eop(in_eop), .in_rdy(in_rdy), .out_vld(out_vld), .out_data(out_data),
      .out_eop(out_eop), .out_rdy(out_rdy), .cur_ch(cur_ch)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // First enabled (and, in skip mode, ready) channel after the last one used.
   function automatic int pick();
      for (int k = 1; k <= 4; k++) begin
         int i = (m_ptr + k) % 4;
         if (ch_en[i] && (!SKIP || out_rdy[i])) return i;
      end
      return -1;
   endfunction

   always @(negedge clks) begin
      if (mon_en) begin
         int c, ch;
         bit drn, er;
         drn = e_vld && out_rdy[e_ch];
         chk("out_vld", 64'(out_vld), e_vld ? 64'(1 << e_ch) : 64'd0);
         if (e_vld) begin
            chk("out_data", out_data, e_data);
            chk("out_eop", 64'(out_eop), 64'(e_eop));
         end
         chk("cur_ch", 64'(cur_ch), 64'(m_lock >= 0 ? m_lock : m_ptr));
         if (reset) begin
            chk("in_rdy_rst", 64'(in_rdy), 64'd0);
            m_ptr = 3; m_lock = -1; e_vld = 1'b0;
         end else begin
            c  = pick();
            er = (!e_vld || drn) && (m_lock >= 0 || c >= 0);
            chk("in_rdy", 64'(in_rdy), 64'(er));
            if (in_vld && er) begin
               ch = m_lock >= 0 ? m_lock : c;
               if (m_lock < 0) m_ptr = c;
               m_lock = in_eop ? -1 : ch;
               e_vld = 1'b1; e_ch = ch; e_data = in_data; e_eop = in_eop;
            end else if (drn) e_vld = 1'b0;
         end
      end
   end

   task automatic cyc();
      @(posedge clks); #1;
   endtask

   task automatic send(input bit eop);
      bit ok = 1'b0;
      in_vld = 1'b1; in_data = seq; in_eop = eop; seq++;
      for (int n = 0; n < 200 && !ok; n++) begin
         @(negedge clks);
         ok = in_rdy;
      end
      if (!ok) chk("send_timeout", 64'd0, 64'd1);
      cyc();
      in_vld = 1'b0;
   endtask

   initial begin
      cyc();
      mon_en = 1'b1;
      cyc();
      reset = 1'b0;
      @(negedge clks);
      chk("rst_out_data", out_data, 64'd0);
      chk("rst_out_eop", 64'(out_eop), 64'd0);
      chk("rst_cur_ch", 64'(cur_ch), 64'd3);
      cyc();
      for (int i = 0; i < 8; i++) send(1'b1);
      for (int i = 0; i < 3; i++) send(i == 2);
      for (int i = 0; i < 2; i++) send(i == 1);
      ch_en = 4'b1010;
      for (int i = 0; i < 4; i++) send(1'b1);
      ch_en = 4'b0100;
      send(1'b0);
      out_rdy = 4'b1011;
      in_vld = 1'b1; in_data = seq; in_eop = 1'b0;
      for (int i = 0; i < 5; i++) cyc();
      out_rdy = 4'hF;
      send(1'b0);
      send(1'b1);
      ch_en = 4'b0010;
      send(1'b0);
      ch_en = 4'b0001;
      send(1'b0);
      send(1'b1);
      send(1'b1);
      ch_en = 4'hF;
      send(1'b0);
      in_vld = 1'b1; in_data = seq; in_eop = 1'b0; reset = 1'b1;
      cyc();
      in_vld = 1'b0;
      @(negedge clks);
      chk("mid_rst_out_vld", 64'(out_vld), 64'd0);
      chk("mid_rst_cur_ch", 64'(cur_ch), 64'd3);
      cyc();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) send(i == 2);
      ch_en = 4'b0000;
      in_vld = 1'b1;
      for (int i = 0; i < 4; i++) cyc();
      in_vld = 1'b0;
      ch_en = 4'hF;
      out_rdy = 4'b1001;
      send(1'b1);
      out_rdy = 4'hF;
      for (int i = 0; i < 3; i++) cyc();
      for (int i = 0; i < 2000; i++) begin
         in_vld  = ($urandom % 4) != 0;
         in_data = {$urandom, $urandom};
         in_eop  = ($urandom % 3) == 0;
         out_rdy = 4'($urandom);
         if ($urandom % 8 == 0) ch_en = 4'($urandom);
         reset   = ($urandom % 300) == 0;
         cyc();
      end
      reset = 1'b0; in_vld = 1'b0; out_rdy = 4'hF;
      for (int i = 0; i < 4; i++) cyc();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
